stack_frame_ctrl: RTL and testbench
===================================

Name: stack_frame_ctrl

Overview:
- Initiator-side controller for the operand stack: turns WebAssembly call-frame requests (CALL, RETURN) into sequences of stack ops on the stack's op/data/offset/new_index/underflow_limit interface, and checks the stack's status after each op.
- Owns the current underflow limit (frame base) and keeps a private LIFO of saved bases.
- Sits between the instruction sequencer and the operand stack.

Parameters:
- WIDTH, 32, stack data width in bits.
- DEPTH, 7, stack depth exponent; stack index/offset ports are DEPTH+1 bits.
- FRAMES, 16, maximum nested frames in the saved-base LIFO (power of two).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready.
- req_op  in  1  0=CALL, 1=RETURN.
- req_count  in  DEPTH+1  CALL: number of arguments; RETURN: number of results.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_err  out  2  valid with resp_valid: 0=OK, 1=BAD_COUNT, 2=FRAME_OVF, 3=NO_FRAME/STACK_FAULT.
- stk_op  out  3  stack op code, using the shared stack op encoding; NONE when idle.
- stk_data  out  WIDTH  stack data.
- stk_offset  out  DEPTH+1  getter/setter offset.
- stk_new_index  out  DEPTH+1  index for INDEX_RESET.
- stk_limit  out  DEPTH+1  current underflow limit (frame base).
- stk_index  in  DEPTH+1  stack current index.
- stk_out  in  WIDTH  stack top or getter output.
- stk_status  in  3  stack status (shared status encoding).
- frame_depth  out  log2(FRAMES)+1  number of live frames.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, stk_op=NONE, stk_data=0, stk_offset=0, stk_new_index=0, stk_limit=0, frame_depth=0, FSM=IDLE.
- Stack timing: an op driven in cycle n produces stk_out, stk_status and stk_index in cycle n+1. stk_op returns to NONE in every cycle the FSM is not issuing an op.
- FSM states: IDLE, CALL, RET_GET, RET_CAP, RET_SET, RET_RST, RET_CHK, RESP.
- IDLE: req_ready=1. Acceptance latches req_op and req_count (C), drops req_ready, and moves to CALL or RET_GET.
- CALL (one cycle), checks in priority order:
  - stk_index - C < stk_limit (unsigned, borrow counts as less): err=BAD_COUNT.
  - frame_depth==FRAMES: err=FRAME_OVF.
  - Otherwise push stk_limit onto the LIFO, frame_depth+1, stk_limit <= stk_index - C, err=OK.
  - Then go to RESP. Any error leaves all state unchanged. CALL total latency is 3 cycles from acceptance to resp_valid.
- RETURN entry checks, in priority order:
  - frame_depth==0: err=NO_FRAME.
  - stk_index - stk_limit < C: err=BAD_COUNT.
  - Either error goes straight to RESP.
  - Otherwise set src = stk_index - C, dst = stk_limit, i = 0.
- Copy loop, skipped entirely when C==0 or src==dst:
  - RET_GET: stk_op=UNDERFLOW_GET, offset=src+i.
  - RET_CAP: capture stk_out. If stk_status==BAD_OFFSET, err=STACK_FAULT and go to RESP.
  - RET_SET: stk_op=UNDERFLOW_SET, offset=dst+i, data=captured value. Then i+1 and return to RET_GET while i<C.
  - Copying proceeds from low to high offset. This is safe because dst<src.
- RET_RST: stk_op=INDEX_RESET, new_index=dst+C.
- RET_CHK:
  - stk_status==BAD_INDEX: err=STACK_FAULT, and the frame is kept.
  - Otherwise pop the LIFO into stk_limit, frame_depth-1, err=OK.
- RESP: resp_valid=1 for exactly one cycle, then IDLE with req_ready=1. The next request may be accepted in the cycle after RESP.
- Width rules: all index arithmetic is modulo 2^(DEPTH+1). Comparisons are unsigned. Borrows are detected explicitly, not by wrap.
- Reset mid-operation: aborts immediately, with no resp_valid. The LIFO contents are discarded (frame_depth=0) and stk_limit=0. The stack itself is reset separately by the system.
- Simultaneous req_valid during busy: ignored (req_ready=0), and the request must be held by the producer.

Optional Feature:
- Macro: STACK_FRAME_CTRL_WATERMARK_EN.
- When defined:
  - Adds output frame_depth_max (same width as frame_depth), the peak frame_depth since reset. It updates in the same cycle frame_depth increases.
  - Adds output overflow_seen (1 bit), which is sticky-set on any FRAME_OVF response.
  - Both outputs clear only on reset.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- CALL with C=2 at stk_index=5, stk_limit=0 -> resp OK after 3 cycles; stk_limit=3, frame_depth=1.
- From that state, 2 pushes make index=7; RETURN C=1 -> GET offset 6, SET offset 3 with that value, INDEX_RESET new_index=4; resp OK, stk_limit=0, frame_depth=0.
- RETURN with frame_depth=0 -> resp_err=NO_FRAME; no stack op issued (stk_op stays NONE).
- CALL with C=4 at stk_index=3, stk_limit=1 -> BAD_COUNT; stk_limit and frame_depth unchanged.
- FRAMES successive CALLs with C=0 succeed; the next one -> FRAME_OVF. With the watermark macro: frame_depth_max=FRAMES and overflow_seen=1.
- Reset asserted during RET_SET of a 3-result RETURN -> next cycle req_ready=1, stk_op=NONE, frame_depth=0, and no resp_valid.

Source files
------------

// File: rtl/stack_frame_ctrl.sv
// rtl/stack_frame_ctrl.sv - call-frame controller turning CALL/RETURN requests into operand-stack ops
//
// Purpose: accepts WebAssembly CALL/RETURN requests, sequences the operand stack through
// underflow get/set and index-reset ops, owns the current underflow limit (frame base)
// and keeps a private LIFO of saved frame bases.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_valid/ready    request handshake; req_op 0=CALL 1=RETURN; req_count = args/results
//   resp_valid         one-cycle completion pulse; resp_err 0=OK 1=BAD_COUNT 2=FRAME_OVF
//                      3=NO_FRAME/STACK_FAULT
//   stk_op/data/offset/new_index/limit   stack command side
//   stk_index/out/status                 stack response side (one cycle after the op)
//   frame_depth        number of live frames
//
// Optional feature macro STACK_FRAME_CTRL_WATERMARK_EN adds:
//   frame_depth_max    peak frame_depth since reset
//   overflow_seen      sticky flag, set on any FRAME_OVF response
//
// Shared stack op encoding:     0 NONE, 1 PUSH, 2 POP, 3 GET, 4 SET,
//                               5 UNDERFLOW_GET, 6 UNDERFLOW_SET, 7 INDEX_RESET
// Shared stack status encoding: 0 OK, 1 EMPTY, 2 FULL, 3 BAD_OFFSET, 4 BAD_INDEX

module stack_frame_ctrl #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 7,
    parameter int FRAMES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_op,
    input  logic [DEPTH:0]            req_count,
    output logic                      resp_valid,
    output logic [1:0]                resp_err,
    output logic [2:0]                stk_op,
    output logic [WIDTH-1:0]          stk_data,
    output logic [DEPTH:0]            stk_offset,
    output logic [DEPTH:0]            stk_new_index,
    output logic [DEPTH:0]            stk_limit,
    input  logic [DEPTH:0]            stk_index,
    input  logic [WIDTH-1:0]          stk_out,
    input  logic [2:0]                stk_status,
    output logic [$clog2(FRAMES):0]   frame_depth
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
    ,
    output logic [$clog2(FRAMES):0]   frame_depth_max,
    output logic                      overflow_seen
`endif
);

    localparam int IW = DEPTH + 1;
    localparam int LW = $clog2(FRAMES);
    localparam int FW = LW + 1;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_UGET  = 3'd5;
    localparam logic [2:0] OP_USET  = 3'd6;
    localparam logic [2:0] OP_IRST  = 3'd7;

    localparam logic [2:0] ST_BAD_OFFSET = 3'd3;
    localparam logic [2:0] ST_BAD_INDEX  = 3'd4;

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_BAD_COUNT = 2'd1;
    localparam logic [1:0] ERR_FRAME_OVF = 2'd2;
    localparam logic [1:0] ERR_FAULT     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CALL, S_RET_GET, S_RET_CAP, S_RET_SET, S_RET_RST, S_RET_CHK, S_RESP
    } state_t;

    state_t             state_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic [1:0]         resp_err_q;
    logic [2:0]         stk_op_q;
    logic [WIDTH-1:0]   stk_data_q;
    logic [IW-1:0]      stk_offset_q;
    logic [IW-1:0]      stk_new_index_q;
    logic [IW-1:0]      stk_limit_q;
    logic [FW-1:0]      frame_depth_q;
    logic [IW-1:0]      cnt_q;
    logic [IW-1:0]      src_q;
    logic [IW-1:0]      i_q;
    logic [IW-1:0]      lifo_q [FRAMES];
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
    logic [FW-1:0]      depth_max_q;
    logic               overflow_seen_q;
`endif

    // CALL: new base is stk_index - C; borrow means fewer values than arguments.
    logic [IW-1:0] call_base;
    logic          call_bad;
    assign call_base = stk_index - cnt_q;
    assign call_bad  = (stk_index < cnt_q) || (call_base < stk_limit_q);

    // RETURN entry checks use the request directly: the stack is idle at acceptance,
    // so stk_index is the value the copy loop will work against.
    logic [IW-1:0] ret_span;
    logic [IW-1:0] ret_src;
    logic          ret_bad;
    logic          ret_skip;
    assign ret_span = stk_index - stk_limit_q;
    assign ret_src  = stk_index - req_count;
    assign ret_bad  = (stk_index < stk_limit_q) || (ret_span < req_count);
    // Nothing to move when there are no results or they already sit at the base.
    assign ret_skip = (req_count == '0) || (ret_src == stk_limit_q);

    logic [IW-1:0] i_next;
    logic [FW-1:0] depth_inc;
    logic [FW-1:0] depth_dec;
    assign i_next    = i_q + 1'b1;
    assign depth_inc = frame_depth_q + 1'b1;
    assign depth_dec = frame_depth_q - 1'b1;

    // Outputs are registered and set on the transition into the state that owns them,
    // so an op is on the bus during its named state and its result is seen one state later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= ERR_OK;
            stk_op_q        <= OP_NONE;
            stk_data_q      <= '0;
            stk_offset_q    <= '0;
            stk_new_index_q <= '0;
            stk_limit_q     <= '0;
            frame_depth_q   <= '0;
            cnt_q           <= '0;
            src_q           <= '0;
            i_q             <= '0;
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
            depth_max_q     <= '0;
            overflow_seen_q <= 1'b0;
`endif
        end else begin
            stk_op_q     <= OP_NONE;
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= req_count;
                        if (!req_op) begin
                            state_q <= S_CALL;
                        end else if (frame_depth_q == '0) begin
                            resp_err_q <= ERR_FAULT;
                            state_q    <= S_RESP;
                        end else if (ret_bad) begin
                            resp_err_q <= ERR_BAD_COUNT;
                            state_q    <= S_RESP;
                        end else begin
                            src_q <= ret_src;
                            i_q   <= '0;
                            if (ret_skip) begin
                                stk_op_q        <= OP_IRST;
                                stk_new_index_q <= stk_limit_q + req_count;
                                state_q         <= S_RET_RST;
                            end else begin
                                stk_op_q     <= OP_UGET;
                                stk_offset_q <= ret_src;
                                state_q      <= S_RET_GET;
                            end
                        end
                    end
                end
                S_CALL: begin
                    if (call_bad) begin
                        resp_err_q <= ERR_BAD_COUNT;
                    end else if (frame_depth_q == FW'(FRAMES)) begin
                        resp_err_q <= ERR_FRAME_OVF;
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
                        overflow_seen_q <= 1'b1;
`endif
                    end else begin
                        lifo_q[frame_depth_q[LW-1:0]] <= stk_limit_q;
                        frame_depth_q <= depth_inc;
                        stk_limit_q   <= call_base;
                        resp_err_q    <= ERR_OK;
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
                        if (depth_inc > depth_max_q) begin
                            depth_max_q <= depth_inc;
                        end
`endif
                    end
                    state_q <= S_RESP;
                end
                S_RET_GET: begin
                    state_q <= S_RET_CAP;
                end
                S_RET_CAP: begin
                    if (stk_status == ST_BAD_OFFSET) begin
                        resp_err_q <= ERR_FAULT;
                        state_q    <= S_RESP;
                    end else begin
                        stk_op_q     <= OP_USET;
                        stk_offset_q <= stk_limit_q + i_q;
                        stk_data_q   <= stk_out;
                        state_q      <= S_RET_SET;
                    end
                end
                S_RET_SET: begin
                    i_q <= i_next;
                    if (i_next < cnt_q) begin
                        stk_op_q     <= OP_UGET;
                        stk_offset_q <= src_q + i_next;
                        state_q      <= S_RET_GET;
                    end else begin
                        stk_op_q        <= OP_IRST;
                        stk_new_index_q <= stk_limit_q + cnt_q;
                        state_q         <= S_RET_RST;
                    end
                end
                S_RET_RST: begin
                    state_q <= S_RET_CHK;
                end
                S_RET_CHK: begin
                    if (stk_status == ST_BAD_INDEX) begin
                        resp_err_q <= ERR_FAULT;
                    end else begin
                        stk_limit_q   <= lifo_q[depth_dec[LW-1:0]];
                        frame_depth_q <= depth_dec;
                        resp_err_q    <= ERR_OK;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b1;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign stk_op        = stk_op_q;
    assign stk_data      = stk_data_q;
    assign stk_offset    = stk_offset_q;
    assign stk_new_index = stk_new_index_q;
    assign stk_limit     = stk_limit_q;
    assign frame_depth   = frame_depth_q;
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
    assign frame_depth_max = depth_max_q;
    assign overflow_seen   = overflow_seen_q;
`endif

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// tb/tb_stack_frame_ctrl.sv - self-checking bench for stack_frame_ctrl with a behavioural stack

module tb_stack_frame_ctrl;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 7;
    localparam int FRAMES = 16;
    localparam int IW     = DEPTH + 1;
    localparam int FW     = $clog2(FRAMES) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_op = 1'b0;
    logic [IW-1:0]    req_count = '0;
    logic             resp_valid;
    logic [1:0]       resp_err;
    logic [2:0]       stk_op;
    logic [WIDTH-1:0] stk_data;
    logic [IW-1:0]    stk_offset;
    logic [IW-1:0]    stk_new_index;
    logic [IW-1:0]    stk_limit;
    logic [IW-1:0]    stk_index;
    logic [WIDTH-1:0] stk_out = '0;
    logic [2:0]       stk_status = '0;
    logic [FW-1:0]    frame_depth;
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
    logic [FW-1:0]    frame_depth_max;
    logic             overflow_seen;
`endif

    stack_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_count(req_count),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .stk_op(stk_op), .stk_data(stk_data), .stk_offset(stk_offset),
        .stk_new_index(stk_new_index), .stk_limit(stk_limit),
        .stk_index(stk_index), .stk_out(stk_out), .stk_status(stk_status),
        .frame_depth(frame_depth)
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
        , .frame_depth_max(frame_depth_max), .overflow_seen(overflow_seen)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural operand stack: index = number of entries, entry k lives at address k.
    logic [WIDTH-1:0] smem [256];
    logic [IW-1:0]    sidx = '0;
    int               tb_cmd = 0;
    logic [31:0]      tb_arg = '0;
    int               inj_kind = 0;
    assign stk_index = sidx;

    always @(posedge clk) begin
        stk_status <= 3'd0;
        if (tb_cmd == 1) begin
            smem[sidx] <= tb_arg;
            sidx <= sidx + 1'b1;
        end else if (tb_cmd == 2) begin
            sidx <= tb_arg[IW-1:0];
        end else begin
            case (stk_op)
                3'd5: begin
                    if (inj_kind == 1 || stk_offset >= sidx) stk_status <= 3'd3;
                    stk_out <= smem[stk_offset];
                end
                3'd6: smem[stk_offset] <= stk_data;
                3'd7: begin
                    if (inj_kind == 2 || stk_new_index > sidx) stk_status <= 3'd4;
                    else sidx <= stk_new_index;
                end
                default: ;
            endcase
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tb_push(input logic [31:0] v);
        tb_cmd = 1; tb_arg = v;
        @(negedge clk);
        tb_cmd = 0;
    endtask

    task automatic set_idx(input int v);
        tb_cmd = 2; tb_arg = v;
        @(negedge clk);
        tb_cmd = 0;
    endtask

    // Ops seen on the stack bus during the last request.
    logic [2:0]    log_op[$];
    logic [IW-1:0] log_off[$];
    logic [IW-1:0] log_new[$];
    logic [31:0]   log_dat[$];

    task automatic do_req(input logic op, input int cnt, output int err, output int lat);
        log_op.delete(); log_off.delete(); log_new.delete(); log_dat.delete();
        err = -1; lat = -1;
        chk("ready_before_req", req_ready, 1);
        req_op = op; req_count = IW'(cnt); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (stk_op != 3'd0) begin
                log_op.push_back(stk_op); log_off.push_back(stk_offset);
                log_new.push_back(stk_new_index); log_dat.push_back(stk_data);
            end
            if (resp_valid) begin
                lat = k; err = int'(resp_err);
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk("resp_timeout", 0, 1);
    endtask

    // Reference model: current base and the list of saved bases.
    int r_limit = 0;
    int r_frames[$];

    task automatic run_req(input logic op, input int c);
        int idx, exp, err, lat;
        logic [31:0] vals[$];
        idx = int'(sidx);
        if (!op) begin
            exp = (idx - c < r_limit) ? 1 : (r_frames.size() == FRAMES) ? 2 : 0;
        end else begin
            exp = (r_frames.size() == 0) ? 3 : (idx - r_limit < c) ? 1 : 0;
            if (exp == 0) for (int k = 0; k < c; k++) vals.push_back(smem[idx - c + k]);
        end
        do_req(op, c, err, lat);
        chk(op ? "ret_err" : "call_err", err, exp);
        if (!op) begin
            chk("call_latency", lat, 3);
            chk("call_index_kept", sidx, idx);
            if (exp == 0) begin
                r_frames.push_back(r_limit);
                r_limit = idx - c;
            end
        end else if (exp == 0) begin
            chk("ret_index", sidx, r_limit + c);
            foreach (vals[k]) chk("ret_data", smem[r_limit + k], vals[k]);
            r_limit = r_frames.pop_back();
        end
        if (exp != 0) chk("err_no_stack_ops", log_op.size(), 0);
        chk("limit", stk_limit, r_limit);
        chk("depth", frame_depth, r_frames.size());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        r_frames.delete();
        r_limit = 0;
    endtask

    initial begin
        int err, lat, seen;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // Reset state
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_stk_op", stk_op, 0);
        chk("rst_stk_data", stk_data, 0);
        chk("rst_stk_offset", stk_offset, 0);
        chk("rst_new_index", stk_new_index, 0);
        chk("rst_limit", stk_limit, 0);
        chk("rst_depth", frame_depth, 0);
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
        chk("rst_depth_max", frame_depth_max, 0);
        chk("rst_ovf_seen", overflow_seen, 0);
`endif

        // CALL C=2 at index 5, limit 0
        set_idx(5);
        run_req(1'b0, 2);
        chk("call1_limit", stk_limit, 3);
        chk("call1_depth", frame_depth, 1);

        // Two pushes, RETURN C=1
        tb_push(32'hA1);
        tb_push(32'hB2);
        run_req(1'b1, 1);
        chk("ret1_nops", log_op.size(), 3);
        if (log_op.size() == 3) begin
            chk("ret1_get_op", log_op[0], 5);
            chk("ret1_get_off", log_off[0], 6);
            chk("ret1_set_op", log_op[1], 6);
            chk("ret1_set_off", log_off[1], 3);
            chk("ret1_set_data", log_dat[1], 32'hB2);
            chk("ret1_rst_op", log_op[2], 7);
            chk("ret1_rst_new", log_new[2], 4);
        end
        chk("ret1_limit", stk_limit, 0);
        chk("ret1_depth", frame_depth, 0);

        // RETURN with no frame
        run_req(1'b1, 0);
        chk("noframe_err", resp_err, 3);

        // CALL C=4 at index 3, limit 1
        set_idx(1);
        run_req(1'b0, 0);
        set_idx(3);
        run_req(1'b0, 4);
        chk("badcnt_err", resp_err, 1);
        chk("badcnt_limit", stk_limit, 1);
        chk("badcnt_depth", frame_depth, 1);
        run_req(1'b1, 0);

        // Stack faults: BAD_OFFSET on the get, BAD_INDEX on the index reset
        tb_push(32'h11); tb_push(32'h22);
        run_req(1'b0, 1);
        tb_push(32'h33);
        inj_kind = 1;
        do_req(1'b1, 1, err, lat);
        chk("fault_get_err", err, 3);
        chk("fault_get_depth", frame_depth, 1);
        chk("fault_get_limit", stk_limit, 2);
        inj_kind = 2;
        do_req(1'b1, 1, err, lat);
        chk("fault_idx_err", err, 3);
        chk("fault_idx_depth", frame_depth, 1);
        chk("fault_idx_limit", stk_limit, 2);
        inj_kind = 0;
        run_req(1'b1, 1);

        // Fill every frame, then overflow
        for (int f = 0; f < FRAMES; f++) run_req(1'b0, 0);
        chk("full_depth", frame_depth, FRAMES);
        run_req(1'b0, 0);
        chk("ovf_err", resp_err, 2);
`ifdef STACK_FRAME_CTRL_WATERMARK_EN
        chk("wm_depth_max", frame_depth_max, FRAMES);
        chk("wm_ovf_seen", overflow_seen, 1);
`endif

        // Reset during RET_SET of a 3-result RETURN
        do_reset();
        set_idx(10);
        run_req(1'b0, 2);
        tb_push(32'h5); tb_push(32'h6); tb_push(32'h7);
        req_op = 1'b1; req_count = IW'(3); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 50 && seen == 0; k++) begin
            if (stk_op == 3'd6) seen = 1;
            else @(negedge clk);
        end
        chk("rst_mid_reached_set", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_op", stk_op, 0);
        chk("rst_mid_depth", frame_depth, 0);
        chk("rst_mid_limit", stk_limit, 0);
        reset = 1'b0;
        r_frames.delete();
        r_limit = 0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid) seen = 1;
            @(negedge clk);
        end
        chk("rst_mid_no_resp", seen, 0);

        // Randomized sequence against the reference model
        for (int n = 0; n < 250; n++) begin
            int np;
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) if (sidx < 200) tb_push($urandom);
            if ($urandom_range(0, 1) == 0) run_req(1'b0, $urandom_range(0, 5));
            else run_req(1'b1, $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
